// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: start-up, stalls, branch redirect bubble window, stop halt.
// Outputs are registered-state decodes one cycle after the inputs are sampled; optional perf counters via FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int bitsize      = 11,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [bitsize-1:0]   branch_target,
  input  logic                 stop_detected,
  output logic                 PC_enable,
  output logic                 PC_source,
  output logic [bitsize-1:0]   PC_jump,
  output logic                 fetch_valid,
  output logic                 flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    STALLED  = 3'd2,
    REDIRECT = 3'd3,
    HALTED   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BUBBLE = 3'(FLUSH_CYCLES - 1);

  state_t             state, state_nxt;
  logic [2:0]         cnt, cnt_nxt;
  logic [bitsize-1:0] target, target_nxt;
  logic               redirect_start;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      target <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      target <= target_nxt;
    end
  end

  // Branch always wins; inside REDIRECT it restarts the bubble window.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    target_nxt     = target;
    redirect_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH, STALLED: begin
        if (branch_taken) begin
          state_nxt      = REDIRECT;
          redirect_start = 1'b1;
        end else if (stop_detected) begin
          state_nxt = HALTED;
        end else if (state == FETCH && stall) begin
          state_nxt = STALLED;
        end else if (state == STALLED && !stall) begin
          state_nxt = FETCH;
        end
      end
      REDIRECT: begin
        if (branch_taken) begin
          redirect_start = 1'b1;
        end else if (cnt == LAST_BUBBLE) begin
          state_nxt = FETCH;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
    if (redirect_start) begin
      cnt_nxt    = 3'd0;
      target_nxt = branch_target;
    end
  end

  logic first_bubble;
  assign first_bubble = (state == REDIRECT) && (cnt == 3'd0);

  assign PC_enable   = (state == FETCH) || first_bubble;
  assign PC_source   = first_bubble;
  assign flush       = first_bubble;
  assign fetch_valid = (state == FETCH);
  assign halted      = (state == HALTED);
  assign PC_jump     = target;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt, redir_cnt;

  // Saturating counters so long runs never wrap into misleading small values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (state == STALLED && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (redirect_start && redir_cnt != '1)   redir_cnt <= redir_cnt + 1'b1;
    end
  end

  assign stall_cycles   = stall_cnt;
  assign redirect_count = redir_cnt;
`else
  assign stall_cycles   = '0;
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations (FLUSH_CYCLES=2).
module tb_fetch_sequencer;

  localparam int BS = 11;
  localparam int CW = 16;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, stall, branch_taken, stop_detected;
  logic [BS-1:0] branch_target;
  logic          PC_enable, PC_source, fetch_valid, flush, halted;
  logic [BS-1:0] PC_jump;
  logic [CW-1:0] stall_cycles, redirect_count;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_sequencer #(.bitsize(BS), .FLUSH_CYCLES(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stop_detected(stop_detected), .PC_enable(PC_enable), .PC_source(PC_source),
    .PC_jump(PC_jump), .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  // ctl = {PC_enable, PC_source, fetch_valid, flush, halted}
  localparam logic [4:0] C_OFF   = 5'b00000;
  localparam logic [4:0] C_FETCH = 5'b10100;
  localparam logic [4:0] C_RDR0  = 5'b11010;
  localparam logic [4:0] C_HALT  = 5'b00001;

  logic [4:0] ctl;
  assign ctl = {PC_enable, PC_source, fetch_valid, flush, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] perf(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    stop_detected = 1'b0; branch_target = '0;
    #2;

    // Reset two cycles, then IDLE, then start.
    tick; tick;
    check("reset_ctl", 32'(ctl), 32'(C_OFF));
    check("reset_jump", 32'(PC_jump), 32'h0);
    check("reset_stallcnt", 32'(stall_cycles), 32'h0);
    check("reset_redircnt", 32'(redirect_count), 32'h0);
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; stop_detected = 1'b1;
    branch_target = 11'h7FF;
    tick;
    check("idle_ignores_inputs", 32'(ctl), 32'(C_OFF));
    check("idle_jump", 32'(PC_jump), 32'h0);
    stall = 1'b0; branch_taken = 1'b0; stop_detected = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_fetch", 32'(ctl), 32'(C_FETCH));

    // Branch in FETCH: two-cycle window.
    branch_taken = 1'b1; branch_target = 11'h1A0;
    tick;
    branch_taken = 1'b0; branch_target = 11'h000;
    check("br_cnt0_ctl", 32'(ctl), 32'(C_RDR0));
    check("br_jump", 32'(PC_jump), 32'h1A0);
    tick;
    check("br_cnt1_ctl", 32'(ctl), 32'(C_OFF));
    check("br_jump_hold", 32'(PC_jump), 32'h1A0);
    tick;
    check("br_resume", 32'(ctl), 32'(C_FETCH));
    check("br_redircnt", 32'(redirect_count), perf(1));

    // Stall three cycles.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("stall_%0d", i), 32'(ctl), 32'(C_OFF));
    end
    stall = 1'b0;
    tick;
    check("stall_release", 32'(ctl), 32'(C_FETCH));
    check("stall_cnt", 32'(stall_cycles), perf(3));
    tick;
    check("stall_cnt_hold", 32'(stall_cycles), perf(3));

    // Branch + stop + stall together: branch wins.
    branch_taken = 1'b1; stop_detected = 1'b1; stall = 1'b1; branch_target = 11'h123;
    tick;
    branch_taken = 1'b0;
    check("prio_redirect", 32'(ctl), 32'(C_RDR0));
    check("prio_jump", 32'(PC_jump), 32'h123);
    // stop and stall still asserted: ignored inside REDIRECT
    tick;
    check("rdr_ignore_cnt1", 32'(ctl), 32'(C_OFF));
    stop_detected = 1'b0; stall = 1'b0;
    tick;
    check("rdr_ignore_exit", 32'(ctl), 32'(C_FETCH));

    // Stop beats stall in FETCH.
    stop_detected = 1'b1; stall = 1'b1;
    tick;
    stop_detected = 1'b0; stall = 1'b0;
    check("halt_enter", 32'(ctl), 32'(C_HALT));
    start = 1'b1; branch_taken = 1'b1;
    tick; tick;
    start = 1'b0; branch_taken = 1'b0;
    check("halt_sticky", 32'(ctl), 32'(C_HALT));
    check("halt_jump_hold", 32'(PC_jump), 32'h123);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("halt_reset_ctl", 32'(ctl), 32'(C_OFF));
    check("halt_reset_redircnt", 32'(redirect_count), 32'h0);
    check("halt_reset_stallcnt", 32'(stall_cycles), 32'h0);

    // Back-to-back branches from a fresh start.
    start = 1'b1;
    tick;
    start = 1'b0;
    check("restart_fetch", 32'(ctl), 32'(C_FETCH));
    branch_taken = 1'b1; branch_target = 11'h040;
    tick;
    check("b2b_first_jump", 32'(PC_jump), 32'h040);
    branch_target = 11'h080;
    tick;
    branch_taken = 1'b0;
    check("b2b_restart_ctl", 32'(ctl), 32'(C_RDR0));
    check("b2b_second_jump", 32'(PC_jump), 32'h080);
    check("b2b_redircnt", 32'(redirect_count), perf(2));
    tick;
    check("b2b_cnt1", 32'(ctl), 32'(C_OFF));
    tick;
    check("b2b_resume", 32'(ctl), 32'(C_FETCH));

    // Branch out of STALLED.
    stall = 1'b1;
    tick;
    check("stalled_again", 32'(ctl), 32'(C_OFF));
    branch_taken = 1'b1; branch_target = 11'h2AA;
    tick;
    branch_taken = 1'b0; stall = 1'b0;
    check("stalled_branch", 32'(ctl), 32'(C_RDR0));
    check("stalled_branch_jump", 32'(PC_jump), 32'h2AA);

    // Reset in the middle of REDIRECT.
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("midrdr_ctl", 32'(ctl), 32'(C_OFF));
    check("midrdr_jump", 32'(PC_jump), 32'h0);
    check("midrdr_redircnt", 32'(redirect_count), 32'h0);
    check("midrdr_stallcnt", 32'(stall_cycles), 32'h0);
    tick;
    check("midrdr_idle", 32'(ctl), 32'(C_OFF));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM for the SPU instruction-fetch stage. It drives the fetch unit's PC load enable, next-PC mux select and jump target. It sequences start-up, stalls, branch redirects with a programmable bubble window, and halting on a stop instruction. It sits between the decode/branch logic and the fetch datapath. It also tells decode when the fetched instruction pair is valid and when in-flight instructions must be flushed.

## Interface
Parameters:
- bitsize, 11, PC width in bits (matches fetch datapath)
- FLUSH_CYCLES, 2, length of the REDIRECT window in cycles (legal 1..7)
- CNT_WIDTH, 16, width of performance counters

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-low; sampled on clk rising edge
- start  input  1  leave IDLE and begin fetching
- stall  input  1  decode/hazard stall request
- branch_taken  input  1  redirect request from branch resolution
- branch_target  input  bitsize  redirect PC, sampled when branch_taken=1
- stop_detected  input  1  stop instruction decoded
- PC_enable  output  1  PC register load enable
- PC_source  output  1  next-PC select: 0 = PC adder, 1 = PC_jump
- PC_jump  output  bitsize  registered redirect target
- fetch_valid  output  1  instruction pair at fetch outputs is valid for decode
- flush  output  1  kill instructions already in decode
- halted  output  1  sequencer is in HALTED
- stall_cycles  output  CNT_WIDTH  stalled-cycle count (see Configuration)
- redirect_count  output  CNT_WIDTH  redirect count (see Configuration)

## Operation
- States: IDLE, FETCH, STALLED, REDIRECT, HALTED. There is a 3-bit bubble counter and a bitsize-bit target register.
- Outputs are decoded only from registered state, counter and target. There is no combinational path from any input to any output.
- IDLE
  - Outputs: all outputs 0.
  - start=1 -> FETCH.
- FETCH
  - Outputs: PC_enable=1, PC_source=0, fetch_valid=1.
  - Transition priority (highest first):
    - branch_taken -> REDIRECT; latch branch_target into PC_jump; counter=0.
    - stop_detected -> HALTED.
    - stall -> STALLED.
    - otherwise stay in FETCH.
- STALLED
  - Outputs: PC_enable=0, fetch_valid=0.
  - Transition priority: branch_taken -> REDIRECT (latch as above); stop_detected -> HALTED; stall=0 -> FETCH.
- REDIRECT
  - Cycle with counter=0: PC_enable=1, PC_source=1, flush=1, fetch_valid=0.
  - Cycles with counter 1..FLUSH_CYCLES-1: PC_enable=0, flush=0, fetch_valid=0.
  - Counter increments each cycle.
  - Exit: counter=FLUSH_CYCLES-1 and no new branch -> FETCH.
  - branch_taken inside REDIRECT re-latches the target, sets counter=0 and restarts the window.
  - stall and stop_detected are ignored inside REDIRECT.
- HALTED
  - Outputs: halted=1, all other control outputs 0.
  - Only reset exits HALTED. start is ignored.
- start is ignored in every state except IDLE.
- PC_jump holds its last latched value outside REDIRECT.
- PC_source is 1 only in the REDIRECT counter=0 cycle.

## Timing
- Reset: reset=0 at an edge puts the block in IDLE, clears counter, PC_jump and the perf counters, and drives every output to 0 from the next cycle. Reset mid-REDIRECT or mid-STALLED aborts immediately.
- start latency: start sampled at edge N gives PC_enable=1 and fetch_valid=1 in cycle N+1.
- Branch sampled in FETCH at edge N:
  - The PC still increments at edge N.
  - Cycle N+1: PC_source=1, flush=1; the PC loads the target at edge N+1.
  - FETCH resumes in cycle N+FLUSH_CYCLES+1.
- FLUSH_CYCLES=1: REDIRECT is one cycle, then FETCH.
- Simultaneous branch_taken, stop_detected and stall: branch wins, stall loses to stop.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - stall_cycles increments every cycle spent in STALLED.
  - redirect_count increments on every entry or restart of REDIRECT.
  - Both saturate at all-ones and clear on reset.
- FETCH_PERF_CNT_EN undefined: both ports remain and are tied to 0; no counter logic is built.

## Test plan
- Reset then start: hold reset=0 two cycles, start=1 one cycle -> all outputs 0 in IDLE; next cycle PC_enable=1, fetch_valid=1, PC_source=0.
- Branch in FETCH with FLUSH_CYCLES=2 and branch_target=11'h1A0:
  - Next cycle: PC_source=1, PC_enable=1, flush=1, PC_jump=0x1A0.
  - Following cycle: PC_enable=0, fetch_valid=0.
  - Then FETCH.
- Stall 3 cycles then release -> PC_enable=0 and fetch_valid=0 for 3 cycles, FETCH the cycle after stall drops; stall_cycles=3 with the macro defined.
- Simultaneous branch_taken, stop_detected and stall in FETCH -> REDIRECT entered, halted=0. stop_detected alone later -> halted=1 permanently; start ignored; reset=0 returns to IDLE.
- Back-to-back branches in REDIRECT (targets 0x040, then 0x080 one cycle later) -> PC_jump=0x080, window restarts, redirect_count=2.
- Reset asserted mid-REDIRECT -> next cycle IDLE, flush=0, PC_jump=0, counters=0.
